obi_wb_bridge: RTL and testbench

- Bridges the core's two OBI-style master ports (instruction fetch, data load/store) onto the single Wishbone-classic master port of the Controller.
- Sits between the soft core and the Controller in processorci_top.
- Replaces the direct wiring of instr_req to core_cyc, which ignores stb, byte enables and the data port.
- Serialises both ports with round-robin arbitration, one outstanding transfer at a time, with a bus-timeout watchdog.

---
 rtl/obi_wb_pkg.sv | 18 +
 rtl/obi_wb_bridge_if.sv | 52 +++++
 rtl/rr_arbiter_2.sv | 38 +++
 rtl/obi_wb_bridge.sv | 126 ++++++++++++
 tb/tb_obi_wb_bridge.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_wb_pkg.sv
// Shared types and constants for the OBI-to-Wishbone bridge.
package obi_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } bridge_state_e;

  typedef enum logic {
    PortInstr,
    PortData
  } port_id_e;

  // Wide enough for any supported data width; users slice the low bits.
  localparam logic [63:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/obi_wb_bridge_if.sv
// Bundles the two OBI ports and the Wishbone master port of the bridge.
// master: the bridge itself; slave: the core/controller environment.
interface obi_wb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    instr_req_i;
  logic                    instr_gnt_o;
  logic [ADDR_WIDTH-1:0]   instr_addr_i;
  logic                    instr_rvalid_o;
  logic [DATA_WIDTH-1:0]   instr_rdata_o;
  logic                    instr_err_o;

  logic                    data_req_i;
  logic                    data_gnt_o;
  logic                    data_we_i;
  logic [DATA_WIDTH/8-1:0] data_be_i;
  logic [ADDR_WIDTH-1:0]   data_addr_i;
  logic [DATA_WIDTH-1:0]   data_wdata_i;
  logic                    data_rvalid_o;
  logic [DATA_WIDTH-1:0]   data_rdata_o;
  logic                    data_err_o;

  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic [ADDR_WIDTH-1:0]   wb_addr_o;
  logic [DATA_WIDTH-1:0]   wb_data_o;
  logic [DATA_WIDTH-1:0]   wb_data_i;
  logic                    wb_ack_i;

  modport master (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
    input  wb_data_i, wb_ack_i
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
    output wb_data_i, wb_ack_i
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; grant is combinational, the pointer
// remembers the last winner so a simultaneous request goes to the other port.
module rr_arbiter_2
  import obi_wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_instr,
  input  logic i_req_data,
  output logic o_gnt_instr,
  output logic o_gnt_data
);

  port_id_e r_last;

  always_comb begin
    o_gnt_instr = 1'b0;
    o_gnt_data  = 1'b0;
    if (i_en) begin
      if (i_req_instr && i_req_data) begin
        if (r_last == PortData) o_gnt_instr = 1'b1;
        else                    o_gnt_data  = 1'b1;
      end else begin
        o_gnt_instr = i_req_instr;
        o_gnt_data  = i_req_data;
      end
    end
  end

  // Reset to data so the instruction port wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)              r_last <= PortData;
    else if (o_gnt_instr) r_last <= PortInstr;
    else if (o_gnt_data)  r_last <= PortData;
  end

endmodule

// File: rtl/obi_wb_bridge.sv
// Serialises the instruction and data OBI ports onto one Wishbone-classic
// master, one transfer at a time, with an optional bus-timeout watchdog.
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  obi_wb_bridge_if.master  bus
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  bridge_state_e         r_state;
  port_id_e              r_owner;
  logic [CntW-1:0]       r_cnt;
  logic                  r_cyc;
  logic                  r_we;
  logic [BeW-1:0]        r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_instr_rvalid, r_instr_err;
  logic                  r_data_rvalid, r_data_err;
  logic [DATA_WIDTH-1:0] r_instr_rdata, r_data_rdata;

  logic                  w_idle, w_gnt_instr, w_gnt_data;
  logic                  w_timeout, w_resp, w_resp_err;
  logic [DATA_WIDTH-1:0] w_resp_rdata;

  assign w_idle = (r_state == StIdle);

  rr_arbiter_2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_idle),
    .i_req_instr (bus.instr_req_i),
    .i_req_data  (bus.data_req_i),
    .o_gnt_instr (w_gnt_instr),
    .o_gnt_data  (w_gnt_data)
  );

  // Counter holds the number of completed ack-less BUS cycles, so the abort
  // edge is the end of BUS cycle TIMEOUT_CYCLES; an ack in that cycle wins.
  always_comb begin
    w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == TimeoutLast);
    w_resp       = (r_state == StBus) && (bus.wb_ack_i || w_timeout);
    w_resp_err   = !bus.wb_ack_i;
    w_resp_rdata = (bus.wb_ack_i && !r_we) ? bus.wb_data_i : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_owner        <= PortInstr;
      r_cnt          <= '0;
      r_cyc          <= 1'b0;
      r_we           <= 1'b0;
      r_sel          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_instr_rvalid <= 1'b0;
      r_instr_err    <= 1'b0;
      r_instr_rdata  <= '0;
      r_data_rvalid  <= 1'b0;
      r_data_err     <= 1'b0;
      r_data_rdata   <= '0;
    end else begin
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_gnt_instr || w_gnt_data) begin
            r_owner <= w_gnt_instr ? PortInstr : PortData;
            r_addr  <= w_gnt_instr ? bus.instr_addr_i : bus.data_addr_i;
            r_we    <= w_gnt_data && bus.data_we_i;
            r_sel   <= w_gnt_instr ? BE_ALL_ONES[BeW-1:0] : bus.data_be_i;
            r_wdata <= w_gnt_instr ? '0 : bus.data_wdata_i;
            r_cnt   <= '0;
            r_cyc   <= 1'b1;
            r_state <= StBus;
          end
        end
        StBus: begin
          if (w_resp) begin
            r_cyc   <= 1'b0;
            r_state <= StResp;
            if (r_owner == PortInstr) begin
              r_instr_rvalid <= 1'b1;
              r_instr_rdata  <= w_resp_rdata;
              r_instr_err    <= w_resp_err;
            end else begin
              r_data_rvalid <= 1'b1;
              r_data_rdata  <= w_resp_rdata;
              r_data_err    <= w_resp_err;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.instr_gnt_o    = w_gnt_instr;
  assign bus.instr_rvalid_o = r_instr_rvalid;
  assign bus.instr_rdata_o  = r_instr_rdata;
  assign bus.instr_err_o    = r_instr_err;
  assign bus.data_gnt_o     = w_gnt_data;
  assign bus.data_rvalid_o  = r_data_rvalid;
  assign bus.data_rdata_o   = r_data_rdata;
  assign bus.data_err_o     = r_data_err;
  assign bus.wb_cyc_o       = r_cyc;
  assign bus.wb_stb_o       = r_cyc;
  assign bus.wb_we_o        = r_we;
  assign bus.wb_sel_o       = r_sel;
  assign bus.wb_addr_o      = r_addr;
  assign bus.wb_data_o      = r_wdata;

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed bench for obi_wb_bridge: reads, writes, round-robin, timeout,
// ack/timeout collision and mid-transfer reset.
module tb_obi_wb_bridge;
  import obi_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  obi_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  obi_wb_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, " cyc"}, bus_if.wb_cyc_o, 1'b0);
    check({tag, " stb"}, bus_if.wb_stb_o, 1'b0);
  endtask

  initial begin
    bus_if.instr_req_i  = 1'b0;
    bus_if.instr_addr_i = '0;
    bus_if.data_req_i   = 1'b0;
    bus_if.data_we_i    = 1'b0;
    bus_if.data_be_i    = '0;
    bus_if.data_addr_i  = '0;
    bus_if.data_wdata_i = '0;
    bus_if.wb_data_i    = '0;
    bus_if.wb_ack_i     = 1'b0;

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check_idle_bus("reset");
    check("reset instr_rvalid", bus_if.instr_rvalid_o, 1'b0);
    check("reset data_rvalid", bus_if.data_rvalid_o, 1'b0);
    check("reset instr_rdata", bus_if.instr_rdata_o, 32'h0);
    check("reset sel", bus_if.wb_sel_o, 4'h0);

    // Instruction read, ack after two wait cycles
    bus_if.instr_req_i  = 1'b1;
    bus_if.instr_addr_i = 32'h0000_0010;
    #1;
    check("t1 instr_gnt", bus_if.instr_gnt_o, 1'b1);
    check("t1 data_gnt", bus_if.data_gnt_o, 1'b0);
    tick();
    bus_if.instr_req_i = 1'b0;
    #1;
    check("t1 cyc c1", bus_if.wb_cyc_o, 1'b1);
    check("t1 stb c1", bus_if.wb_stb_o, 1'b1);
    check("t1 sel", bus_if.wb_sel_o, 4'hF);
    check("t1 we", bus_if.wb_we_o, 1'b0);
    check("t1 addr", bus_if.wb_addr_o, 32'h0000_0010);
    tick();
    check("t1 cyc c2", bus_if.wb_cyc_o, 1'b1);
    tick();
    bus_if.wb_ack_i  = 1'b1;
    bus_if.wb_data_i = 32'h0000_0013;
    check("t1 cyc c3", bus_if.wb_cyc_o, 1'b1);
    check("t1 no early rvalid", bus_if.instr_rvalid_o, 1'b0);
    tick();
    bus_if.wb_ack_i = 1'b0;
    check_idle_bus("t1 after ack");
    check("t1 instr_rvalid", bus_if.instr_rvalid_o, 1'b1);
    check("t1 instr_rdata", bus_if.instr_rdata_o, 32'h0000_0013);
    check("t1 instr_err", bus_if.instr_err_o, 1'b0);
    check("t1 data_rvalid", bus_if.data_rvalid_o, 1'b0);
    tick();
    check("t1 rvalid one cycle", bus_if.instr_rvalid_o, 1'b0);
    check("t1 rdata held", bus_if.instr_rdata_o, 32'h0000_0013);

    // Data write, immediate ack
    bus_if.data_req_i   = 1'b1;
    bus_if.data_we_i    = 1'b1;
    bus_if.data_be_i    = 4'h3;
    bus_if.data_addr_i  = 32'h8000_0004;
    bus_if.data_wdata_i = 32'hCAFE_BABE;
    #1;
    check("t2 data_gnt", bus_if.data_gnt_o, 1'b1);
    check("t2 instr_gnt", bus_if.instr_gnt_o, 1'b0);
    tick();
    bus_if.data_req_i = 1'b0;
    bus_if.wb_ack_i   = 1'b1;
    bus_if.wb_data_i  = 32'hDEAD_0000;
    check("t2 cyc", bus_if.wb_cyc_o, 1'b1);
    check("t2 we", bus_if.wb_we_o, 1'b1);
    check("t2 sel", bus_if.wb_sel_o, 4'h3);
    check("t2 addr", bus_if.wb_addr_o, 32'h8000_0004);
    check("t2 wdata", bus_if.wb_data_o, 32'hCAFE_BABE);
    tick();
    bus_if.wb_ack_i = 1'b0;
    check("t2 data_rvalid", bus_if.data_rvalid_o, 1'b1);
    check("t2 data_rdata", bus_if.data_rdata_o, 32'h0);
    check("t2 data_err", bus_if.data_err_o, 1'b0);
    check("t2 instr_rvalid", bus_if.instr_rvalid_o, 1'b0);
    check("t2 cyc dropped", bus_if.wb_cyc_o, 1'b0);
    tick();

    // Both ports request continuously for four transfers
    bus_if.instr_req_i  = 1'b1;
    bus_if.instr_addr_i = 32'h0000_0100;
    bus_if.data_req_i   = 1'b1;
    bus_if.data_we_i    = 1'b0;
    bus_if.data_be_i    = 4'hF;
    bus_if.data_addr_i  = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      logic is_instr;
      is_instr = (i % 2 == 0);
      #1;
      check($sformatf("t3 instr_gnt %0d", i), bus_if.instr_gnt_o, is_instr);
      check($sformatf("t3 data_gnt %0d", i), bus_if.data_gnt_o, !is_instr);
      tick();
      bus_if.wb_ack_i  = 1'b1;
      bus_if.wb_data_i = 32'h0000_1000 + 32'(i);
      check($sformatf("t3 addr %0d", i), bus_if.wb_addr_o,
            is_instr ? 32'h0000_0100 : 32'h0000_0200);
      check($sformatf("t3 no gnt in bus %0d", i),
            {bus_if.instr_gnt_o, bus_if.data_gnt_o}, 2'b00);
      tick();
      bus_if.wb_ack_i = 1'b0;
      check($sformatf("t3 instr_rvalid %0d", i), bus_if.instr_rvalid_o, is_instr);
      check($sformatf("t3 data_rvalid %0d", i), bus_if.data_rvalid_o, !is_instr);
      check($sformatf("t3 rdata %0d", i),
            is_instr ? bus_if.instr_rdata_o : bus_if.data_rdata_o, 32'h0000_1000 + 32'(i));
      check($sformatf("t3 no gnt in resp %0d", i),
            {bus_if.instr_gnt_o, bus_if.data_gnt_o}, 2'b00);
      tick();
    end
    bus_if.instr_req_i = 1'b0;
    bus_if.data_req_i  = 1'b0;
    tick();

    // Timeout: data read never acked
    bus_if.data_req_i  = 1'b1;
    bus_if.data_addr_i = 32'h0000_0300;
    #1;
    check("t4 data_gnt", bus_if.data_gnt_o, 1'b1);
    tick();
    bus_if.data_req_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("t4 cyc c%0d", c), bus_if.wb_cyc_o, 1'b1);
      tick();
    end
    check_idle_bus("t4 abort");
    check("t4 data_rvalid", bus_if.data_rvalid_o, 1'b1);
    check("t4 data_err", bus_if.data_err_o, 1'b1);
    check("t4 data_rdata", bus_if.data_rdata_o, 32'h0);
    tick();
    check("t4 rvalid one cycle", bus_if.data_rvalid_o, 1'b0);
    check("t4 err held", bus_if.data_err_o, 1'b1);

    // Normal transfer after the timeout
    bus_if.instr_req_i  = 1'b1;
    bus_if.instr_addr_i = 32'h0000_0040;
    #1;
    check("t4b instr_gnt", bus_if.instr_gnt_o, 1'b1);
    tick();
    bus_if.instr_req_i = 1'b0;
    bus_if.wb_ack_i    = 1'b1;
    bus_if.wb_data_i   = 32'h0000_0055;
    check("t4b addr", bus_if.wb_addr_o, 32'h0000_0040);
    tick();
    bus_if.wb_ack_i = 1'b0;
    check("t4b instr_rvalid", bus_if.instr_rvalid_o, 1'b1);
    check("t4b instr_rdata", bus_if.instr_rdata_o, 32'h0000_0055);
    check("t4b instr_err", bus_if.instr_err_o, 1'b0);
    tick();

    // Ack in the same cycle the watchdog expires
    bus_if.data_req_i  = 1'b1;
    bus_if.data_addr_i = 32'h0000_0500;
    tick();
    bus_if.data_req_i = 1'b0;
    for (int c = 1; c <= 7; c++) tick();
    bus_if.wb_ack_i  = 1'b1;
    bus_if.wb_data_i = 32'h0000_A5A5;
    check("t5 cyc c8", bus_if.wb_cyc_o, 1'b1);
    tick();
    bus_if.wb_ack_i = 1'b0;
    check("t5 data_rvalid", bus_if.data_rvalid_o, 1'b1);
    check("t5 data_err", bus_if.data_err_o, 1'b0);
    check("t5 data_rdata", bus_if.data_rdata_o, 32'h0000_A5A5);
    tick();

    // Reset in the second BUS cycle of a read
    bus_if.instr_req_i  = 1'b1;
    bus_if.instr_addr_i = 32'h0000_0060;
    tick();
    bus_if.instr_req_i = 1'b0;
    check("t6 cyc c1", bus_if.wb_cyc_o, 1'b1);
    tick();
    rst = 1'b1;
    check("t6 cyc c2", bus_if.wb_cyc_o, 1'b1);
    tick();
    rst             = 1'b0;
    bus_if.wb_ack_i = 1'b1;
    bus_if.wb_data_i = 32'h0000_0BAD;
    check_idle_bus("t6 after rst");
    check("t6 instr_rvalid", bus_if.instr_rvalid_o, 1'b0);
    check("t6 instr_rdata cleared", bus_if.instr_rdata_o, 32'h0);
    tick();
    bus_if.wb_ack_i = 1'b0;
    check("t6 stray ack rvalid", bus_if.instr_rvalid_o | bus_if.data_rvalid_o, 1'b0);
    check_idle_bus("t6 stray ack");
    bus_if.instr_req_i  = 1'b1;
    bus_if.instr_addr_i = 32'h0000_0070;
    #1;
    check("t6 instr_gnt", bus_if.instr_gnt_o, 1'b1);
    tick();
    bus_if.instr_req_i = 1'b0;
    bus_if.wb_ack_i    = 1'b1;
    bus_if.wb_data_i   = 32'h0000_0077;
    check("t6 addr", bus_if.wb_addr_o, 32'h0000_0070);
    tick();
    bus_if.wb_ack_i = 1'b0;
    check("t6 instr_rvalid after", bus_if.instr_rvalid_o, 1'b1);
    check("t6 instr_rdata after", bus_if.instr_rdata_o, 32'h0000_0077);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
